// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over a
// programmable window of gate_len clk cycles and reports the result with a done pulse.
module freq_meter #(
  parameter int CNT_W  = 8,
  parameter int GATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GATE = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic              rise;
  logic [GATE_W-1:0] gc_q, gc_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  acc_inc;
  logic [CNT_W-1:0]  count_q, count_d;

  // sig_in is asynchronous: two flops for metastability, a third for edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign acc_inc = (rise && (acc_q != {CNT_W{1'b1}})) ? acc_q + CNT_W'(1) : acc_q;

  always_comb begin
    state_d = state_q;
    gc_d    = gc_q;
    acc_d   = acc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          gc_d  = gate_len;
          acc_d = '0;
          if (gate_len != '0) begin
            state_d = GATE;
          end else begin
            state_d = DONE;
            count_d = '0;
          end
        end
      end
      GATE: begin
        gc_d  = gc_q - GATE_W'(1);
        acc_d = acc_inc;
        // Last window cycle: publish the count including this cycle's rise.
        if (gc_q == GATE_W'(1)) begin
          state_d = DONE;
          count_d = acc_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gc_q    <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gc_q    <= gc_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign count = count_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: two instances (8-bit and 4-bit count) share
// stimulus; expected counts come from a history of sampled sig_in values.
module tb_freq_meter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic [7:0] gate_len = 8'd0;
  logic       busy8, done8, busy4, done4;
  logic [7:0] count8;
  logic [3:0] count4;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int hp = 4;
  int phase = 0;
  int lvl = 0;
  int exp8 = 0;
  int exp4 = 0;
  bit hist[$];

  always #5 clk = ~clk;

  freq_meter #(.CNT_W(8), .GATE_W(8)) dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .gate_len(gate_len),
    .busy(busy8), .done(done8), .count(count8)
  );

  freq_meter #(.CNT_W(4), .GATE_W(8)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .gate_len(gate_len),
    .busy(busy4), .done(done4), .count(count4)
  );

  task automatic check_eq(input string tag, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // hist[i] holds sig_in as sampled at posedge (i-2) since the last reset release;
  // the two leading zeros stand for the cleared synchronizer flops.
  task automatic clear_hist();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  task automatic tick();
    case (mode)
      0: sig_in = lvl[0];
      1: begin
        if (phase >= hp) begin
          sig_in = ~sig_in;
          phase  = 0;
        end
        phase++;
      end
      default: sig_in = 1'($urandom_range(0, 1));
    endcase
    hist.push_back(sig_in);
    @(posedge clk);
    #1;
  endtask

  // A synchronized rise is visible two cycles after sampling; cycles of the window
  // follow posedges a .. a+gl-1, so count 0->1 transitions of the sampled history there.
  function automatic int model_count(input int a, input int gl, input int sat);
    int n = 0;
    for (int k = a; k < a + gl; k++)
      if (hist[k+1] && !hist[k]) n++;
    return (n > sat) ? sat : n;
  endfunction

  task automatic check_outs(input string tag, input int b, input int d);
    check_eq({tag, "_busy8"}, int'(busy8), b);
    check_eq({tag, "_done8"}, int'(done8), d);
    check_eq({tag, "_busy4"}, int'(busy4), b);
    check_eq({tag, "_done4"}, int'(done4), d);
    check_eq({tag, "_count8"}, int'(count8), exp8);
    check_eq({tag, "_count4"}, int'(count4), exp4);
  endtask

  task automatic measure(input int gl, input bit hold, input bit repulse);
    int a;
    start    = 1'b1;
    gate_len = gl[7:0];
    tick();
    a = hist.size() - 3;
    for (int c = 1; c <= gl + 1; c++) begin
      if (c > 1) begin
        if (repulse && c == 2 + gl / 2) begin
          start    = 1'b1;
          gate_len = 8'($urandom_range(1, 200));
        end else begin
          if (!hold) start = 1'b0;
          gate_len = 8'($urandom);
        end
        tick();
      end
      if (c == gl + 1) begin
        exp8 = model_count(a, gl, 255);
        exp4 = model_count(a, gl, 15);
        $display("meas gl=%0d hold=%0d repulse=%0d count8=%0d/%0d count4=%0d/%0d",
                 gl, hold, repulse, count8, exp8, count4, exp4);
      end
      check_outs("win", 1, (c == gl + 1) ? 1 : 0);
    end
    if (!hold) start = 1'b0;
    tick();
    check_outs("after", 0, 0);
  endtask

  task automatic reset_mid(input int gl, input int k);
    start    = 1'b1;
    gate_len = gl[7:0];
    tick();
    start = 1'b0;
    repeat (k) tick();
    rst = 1'b0;
    #1;
    exp8 = 0;
    exp4 = 0;
    check_outs("rst_mid", 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("rst_hold", 0, 0);
    rst = 1'b1;
    clear_hist();
    for (int i = 0; i < gl + 4; i++) begin
      tick();
      check_outs("post_rst", 0, 0);
    end
    $display("reset_mid gl=%0d k=%0d busy8=%0d count8=%0d", gl, k, busy8, count8);
  endtask

  initial begin
    clear_hist();
    #1;
    check_outs("reset_async", 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("reset_clk", 0, 0);
    rst = 1'b1;
    clear_hist();
    $display("reset released");

    // sig_in toggling every 4 clk, 64-cycle window
    mode = 1; hp = 4;
    repeat (3) tick();
    measure(64, 1'b0, 1'b0);
    check_eq("p8_window", (count8 >= 7 && count8 <= 9) ? 1 : 0, 1);

    // sig_in steady high: no edges
    mode = 0; lvl = 1;
    repeat (5) tick();
    measure(20, 1'b0, 1'b0);
    check_eq("level_zero", int'(count8), 0);

    // zero-length window
    mode = 2;
    measure(0, 1'b0, 1'b0);

    // period 4 over 64 cycles: 4-bit result saturates
    mode = 1; hp = 2;
    measure(64, 1'b0, 1'b0);
    check_eq("sat4", int'(count4), 15);

    // restart attempt mid-window is ignored
    mode = 2;
    measure(30, 1'b0, 1'b1);

    // reset in the middle of a window and during DONE
    mode = 1; hp = 3;
    reset_mid(40, 10);
    reset_mid(5, 5);

    // start held high: back-to-back windows with one idle cycle between
    mode = 2;
    for (int w = 0; w < 3; w++) measure(10, 1'b1, 1'b0);
    start = 1'b0;
    tick();

    for (int it = 0; it < 30; it++) begin
      mode = $urandom_range(0, 2);
      hp   = $urandom_range(1, 5);
      lvl  = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) tick();
      begin
        int gl;
        gl = $urandom_range(0, 40);
        measure(gl, 1'b0, (gl >= 2) && ($urandom_range(0, 2) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
